chave_scan_ctrl: RTL and testbench

//  Sequencer that owns the 4-bit select of the 16:1 switch mux (CH[0..15] -> S).

---
 rtl/chave_pkg.sv | 21 ++
 rtl/chave_debounce_bank.sv | 62 ++++++
 rtl/chave_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_chave_scan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chave_pkg.sv
// Shared definitions for the switch-scan controller: channel count, select width
// and the sequencer state encoding.
package chave_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_SET,
        SCAN_SMP,
        REQ_SET,
        REQ_SMP
    } scan_state_t;

    // The host port may only be accepted where the mux is free to be retargeted.
    function automatic logic is_ready_state(input scan_state_t s);
        return (s == IDLE) || (s == SCAN_SMP);
    endfunction

endpackage

// File: rtl/chave_debounce_bank.sv
// Per-channel debounce counters feeding the 16-bit debounced switch-state register.
// One channel is updated per sample strobe; chg pulses alongside each state flip.
module chave_debounce_bank
    import chave_pkg::*;
#(
    parameter int DEB_CNT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             smp_en_i,
    input  logic [SEL_W-1:0] smp_ch_i,
    input  logic             smp_val_i,
    output logic [N_CH-1:0]  sw_state_o,
    output logic             chg_o
);

    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  sw_state_q;
    logic [N_CH-1:0]  sw_state_d;
    logic             chg_q;
    logic             chg_d;

    // A sample that agrees with the stored state clears any pending disagreement.
    always_comb begin
        cnt_d      = cnt_q;
        sw_state_d = sw_state_q;
        chg_d      = 1'b0;
        if (smp_en_i) begin
            if (smp_val_i == sw_state_q[smp_ch_i]) begin
                cnt_d[smp_ch_i] = '0;
            end else if (cnt_q[smp_ch_i] == CNT_LAST) begin
                sw_state_d[smp_ch_i] = ~sw_state_q[smp_ch_i];
                cnt_d[smp_ch_i]      = '0;
                chg_d                = 1'b1;
            end else begin
                cnt_d[smp_ch_i] = cnt_q[smp_ch_i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            sw_state_q <= '0;
            chg_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sw_state_q <= sw_state_d;
            chg_q      <= chg_d;
        end
    end

    assign sw_state_o = sw_state_q;
    assign chg_o      = chg_q;

endmodule

// File: rtl/chave_scan_ctrl.sv
// Owner of the 16:1 switch-mux select: round-robin debounced scan with an
// interleaved, higher-priority one-shot host read port.
module chave_scan_ctrl
    import chave_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int DEB_CNT    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scan_en_i,
    output logic [SEL_W-1:0] sel_o,
    input  logic             mux_s_i,
    input  logic             req_valid_i,
    input  logic [SEL_W-1:0] req_ch_i,
    output logic             req_ready_o,
    output logic             rsp_valid_o,
    output logic             rsp_data_o,
    output logic [N_CH-1:0]  sw_state_o,
    output logic             chg_o,
    output logic             scan_done_o
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic             rsp_valid_q;
    logic             rsp_data_q;
    logic             scan_done_q;
    logic             req_fire;

    assign req_ready_o = is_ready_state(state_q) && !rst_i;
    assign req_fire    = req_valid_i && req_ready_o;

    // Every entry into a *_SET state restarts the settle counter from zero.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        set_cnt_d = set_cnt_q;
        case (state_q)
            IDLE: begin
                set_cnt_d = '0;
                if (req_fire) begin
                    state_d = REQ_SET;
                    sel_d   = req_ch_i;
                end else if (scan_en_i) begin
                    state_d = SCAN_SET;
                    sel_d   = ptr_q;
                end
            end
            SCAN_SET: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = SCAN_SMP;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            SCAN_SMP: begin
                ptr_d     = ptr_q + SEL_W'(1);
                set_cnt_d = '0;
                if (req_fire) begin
                    state_d = REQ_SET;
                    sel_d   = req_ch_i;
                end else if (scan_en_i) begin
                    state_d = SCAN_SET;
                    sel_d   = ptr_d;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ_SET: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = REQ_SMP;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            REQ_SMP: begin
                set_cnt_d = '0;
                if (scan_en_i) begin
                    state_d = SCAN_SET;
                    sel_d   = ptr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            set_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            set_cnt_q   <= set_cnt_d;
            rsp_valid_q <= (state_q == REQ_SMP);
            scan_done_q <= (state_q == SCAN_SMP) && (ptr_q == LAST_CH);
            if (state_q == REQ_SMP) begin
                rsp_data_q <= mux_s_i;
            end
        end
    end

    // Host samples bypass the debouncer; only scan samples are filtered.
    chave_debounce_bank #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .smp_en_i   (state_q == SCAN_SMP),
        .smp_ch_i   (ptr_q),
        .smp_val_i  (mux_s_i),
        .sw_state_o (sw_state_o),
        .chg_o      (chg_o)
    );

    assign sel_o       = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_chave_scan_ctrl.sv
// Scenario bench for chave_scan_ctrl: a behavioural 16:1 switch mux plus a
// response scoreboard fed at request acceptance.
`timescale 1ns/1ps
module tb_chave_scan_ctrl;
    import chave_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scanEn = 1'b0;
    logic [3:0]  sel;
    logic        muxS;
    logic        reqValid = 1'b0;
    logic [3:0]  reqCh = 4'd0;
    logic        reqReady;
    logic        rspValid;
    logic        rspData;
    logic [15:0] swState;
    logic        chg;
    logic        scanDone;
    logic [15:0] chVec = 16'h0000;

    int checkCount = 0;
    int passCount  = 0;
    int chgCount   = 0;
    int doneCount  = 0;
    int relCyc     = 0;
    logic expQ[$];
    logic monExp;

    always #5 clk = ~clk;

    assign muxS = chVec[sel];

    chave_scan_ctrl #(.SETTLE_CYC(4), .DEB_CNT(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scan_en_i   (scanEn),
        .sel_o       (sel),
        .mux_s_i     (muxS),
        .req_valid_i (reqValid),
        .req_ch_i    (reqCh),
        .req_ready_o (reqReady),
        .rsp_valid_o (rspValid),
        .rsp_data_o  (rspData),
        .sw_state_o  (swState),
        .chg_o       (chg),
        .scan_done_o (scanDone)
    );

    // Response scoreboard and pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rspValid === 1'b1) begin
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL rsp_unexpected: rsp_valid=1 rsp_data=%0b, no response outstanding", rspData);
            end else begin
                monExp = expQ.pop_front();
                if (rspData !== monExp) $display("[TB] FAIL rsp_data: got %0b expected %0b", rspData, monExp);
                else passCount++;
            end
        end
        if (chg === 1'b1) chgCount++;
        if (scanDone === 1'b1) doneCount++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
        relCyc++;
    endtask

    task automatic tick_to(input int k);
        while (relCyc < k) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqValid = 1'b0;
        tick();
        tick();
        checkCount++;
        if (sel !== 4'd0 || swState !== 16'h0000) $display("[TB] FAIL reset_regs: sel=%0d sw_state=%h expected 0/0000", sel, swState);
        else passCount++;
        checkCount++;
        if (rspValid !== 1'b0 || rspData !== 1'b0 || chg !== 1'b0 || scanDone !== 1'b0 || reqReady !== 1'b0)
            $display("[TB] FAIL reset_flags: rsp_valid=%0b rsp_data=%0b chg=%0b scan_done=%0b req_ready=%0b expected all 0",
                     rspValid, rspData, chg, scanDone, reqReady);
        else passCount++;
        rst = 1'b0;
        relCyc = 0;
    endtask

    task automatic test_scan();
        int chg0;
        int done0;
        chVec  = 16'hA5A5;
        scanEn = 1'b1;
        test_reset();
        chg0  = chgCount;
        done0 = doneCount;
        for (int n = 0; n < 48; n++) begin
            bit slotOk;
            logic [3:0] bad;
            slotOk = 1'b1;
            bad = 4'd0;
            for (int j = 0; j < 5; j++) begin
                tick();
                if (sel !== 4'(n % 16)) begin
                    slotOk = 1'b0;
                    bad = sel;
                end
                if (relCyc == 81) begin
                    checkCount++;
                    if (scanDone !== 1'b1) $display("[TB] FAIL scan_done_wrap: scan_done=%0b expected 1", scanDone);
                    else passCount++;
                end
                if (relCyc == 161) begin
                    checkCount++;
                    if (swState !== 16'h0000) $display("[TB] FAIL scan_two_passes: sw_state=%h expected 0000", swState);
                    else passCount++;
                end
            end
            checkCount++;
            if (!slotOk) $display("[TB] FAIL scan_sel_slot%0d: sel=%0d expected %0d for 5 cycles", n, bad, n % 16);
            else passCount++;
        end
        tick();
        tick();
        checkCount++;
        if (swState !== 16'hA5A5) $display("[TB] FAIL scan_sw_state: sw_state=%h expected a5a5", swState);
        else passCount++;
        checkCount++;
        if (chgCount - chg0 !== 8) $display("[TB] FAIL scan_chg_count: %0d pulses expected 8", chgCount - chg0);
        else passCount++;
        checkCount++;
        if (doneCount - done0 !== 3) $display("[TB] FAIL scan_done_count: %0d pulses expected 3", doneCount - done0);
        else passCount++;
    endtask

    task automatic test_req_idle();
        bit latOk;
        chVec  = 16'h0200;
        scanEn = 1'b0;
        test_reset();
        tick();
        reqValid = 1'b1;
        reqCh    = 4'd9;
        checkCount++;
        if (reqReady !== 1'b1) $display("[TB] FAIL req_ready_idle: req_ready=%0b expected 1", reqReady);
        else passCount++;
        expQ.push_back(chVec[9]);
        tick();
        reqValid = 1'b0;
        checkCount++;
        if (sel !== 4'd9 || reqReady !== 1'b0) $display("[TB] FAIL req_sel: sel=%0d req_ready=%0b expected 9/0", sel, reqReady);
        else passCount++;
        latOk = 1'b1;
        for (int k = 3; k <= 9; k++) begin
            tick();
            if (rspValid !== (relCyc == 7)) latOk = 1'b0;
        end
        checkCount++;
        if (!latOk) $display("[TB] FAIL req_latency: rsp_valid not high exactly 6 cycles after accept");
        else passCount++;
        checkCount++;
        if (swState !== 16'h0000) $display("[TB] FAIL req_sw_untouched: sw_state=%h expected 0000", swState);
        else passCount++;
    endtask

    task automatic test_req_during_scan();
        chVec  = 16'h1000;
        scanEn = 1'b1;
        test_reset();
        tick_to(17);
        reqValid = 1'b1;
        reqCh    = 4'd12;
        checkCount++;
        if (reqReady !== 1'b0) $display("[TB] FAIL req_hold_set: req_ready=%0b expected 0", reqReady);
        else passCount++;
        tick_to(20);
        checkCount++;
        if (reqReady !== 1'b1 || sel !== 4'd3) $display("[TB] FAIL req_at_smp: req_ready=%0b sel=%0d expected 1/3", reqReady, sel);
        else passCount++;
        expQ.push_back(chVec[12]);
        tick();
        reqValid = 1'b0;
        checkCount++;
        if (sel !== 4'd12) $display("[TB] FAIL req_scan_sel: sel=%0d expected 12", sel);
        else passCount++;
        tick_to(26);
        checkCount++;
        if (sel !== 4'd4 || rspValid !== 1'b1) $display("[TB] FAIL scan_resume: sel=%0d rsp_valid=%0b expected 4/1", sel, rspValid);
        else passCount++;
        tick_to(31);
        checkCount++;
        if (sel !== 4'd5) $display("[TB] FAIL scan_no_skip: sel=%0d expected 5", sel);
        else passCount++;
    endtask

    task automatic test_glitch();
        int chg0;
        chVec  = 16'h0020;
        scanEn = 1'b1;
        test_reset();
        chg0 = chgCount;
        tick_to(111);
        chVec = 16'h0000;
        tick_to(320);
        checkCount++;
        if (swState !== 16'h0000 || chgCount !== chg0)
            $display("[TB] FAIL glitch_rejected: sw_state=%h chg pulses=%0d expected 0000/0", swState, chgCount - chg0);
        else passCount++;
        chVec = 16'h0020;
        tick_to(432);
        checkCount++;
        if (swState !== 16'h0000) $display("[TB] FAIL glitch_two_held: sw_state=%h expected 0000", swState);
        else passCount++;
        tick_to(520);
        checkCount++;
        if (swState !== 16'h0020 || chgCount - chg0 !== 1)
            $display("[TB] FAIL glitch_flip: sw_state=%h chg pulses=%0d expected 0020/1", swState, chgCount - chg0);
        else passCount++;
    endtask

    task automatic test_reset_mid_req();
        bit quiet;
        chVec  = 16'hFFFF;
        scanEn = 1'b1;
        test_reset();
        tick_to(242);
        scanEn = 1'b0;
        checkCount++;
        if (swState !== 16'hFFFF) $display("[TB] FAIL prerst_state: sw_state=%h expected ffff", swState);
        else passCount++;
        tick_to(246);
        checkCount++;
        if (reqReady !== 1'b1) $display("[TB] FAIL prerst_idle: req_ready=%0b expected 1", reqReady);
        else passCount++;
        reqValid = 1'b1;
        reqCh    = 4'd4;
        tick();
        reqValid = 1'b0;
        checkCount++;
        if (sel !== 4'd4) $display("[TB] FAIL prerst_sel: sel=%0d expected 4", sel);
        else passCount++;
        tick();
        rst = 1'b1;
        tick();
        checkCount++;
        if (sel !== 4'd0 || swState !== 16'h0000 || rspValid !== 1'b0)
            $display("[TB] FAIL rst_mid_req: sel=%0d sw_state=%h rsp_valid=%0b expected 0/0000/0", sel, swState, rspValid);
        else passCount++;
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rspValid !== 1'b0) quiet = 1'b0;
        end
        checkCount++;
        if (!quiet || sel !== 4'd0) $display("[TB] FAIL rst_drop_rsp: rsp seen=%0b sel=%0d expected 0/0", !quiet, sel);
        else passCount++;
    endtask

    task automatic test_scan_stop();
        chVec  = 16'h0080;
        scanEn = 1'b1;
        test_reset();
        tick_to(37);
        scanEn = 1'b0;
        tick();
        checkCount++;
        if (reqReady !== 1'b0 || sel !== 4'd7) $display("[TB] FAIL stop_settling: req_ready=%0b sel=%0d expected 0/7", reqReady, sel);
        else passCount++;
        tick_to(40);
        checkCount++;
        if (reqReady !== 1'b1 || sel !== 4'd7) $display("[TB] FAIL stop_sample: req_ready=%0b sel=%0d expected 1/7", reqReady, sel);
        else passCount++;
        tick_to(50);
        checkCount++;
        if (sel !== 4'd7) $display("[TB] FAIL stop_park: sel=%0d expected 7", sel);
        else passCount++;
        scanEn = 1'b1;
        tick();
        checkCount++;
        if (sel !== 4'd8) $display("[TB] FAIL stop_resume: sel=%0d expected 8", sel);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_reset();
        test_req_idle();
        test_req_during_scan();
        test_glitch();
        test_reset_mid_req();
        test_scan_stop();
        tick();
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL rsp_outstanding: %0d responses never arrived", expQ.size());
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
